// File: rtl/ssp_param_if.sv
// Peripheral-bus side of ssp_param: write pushes the TX FIFO, read pops the RX FIFO.
interface ssp_param_if #(
   parameter int DATA_W = 8
);
   logic              PSEL;
   logic              PWRITE;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;

   modport master (output PSEL, output PWRITE, output PWDATA, input PRDATA);
   modport slave  (input PSEL, input PWRITE, input PWDATA, output PRDATA);
endinterface

// File: rtl/ssp_param.sv
// Parametrised TI-frame synchronous serial port: TX/RX FIFOs, serial clock divider,
// PCLK-synchronous receiver with optional internal loopback and sticky overrun.
module ssp_param #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CLK_DIV    = 8,
   parameter int LSB_FIRST  = 0
) (
   input  logic       PCLK,
   input  logic       CLEAR,
   ssp_param_if.slave bus,
   input  logic       LOOPBACK,
   input  logic       SSPCLKIN,
   input  logic       SSPFSSIN,
   input  logic       SSPRXD,
   output logic       SSPCLKOUT,
   output logic       SSPFSSOUT,
   output logic       SSPTXD,
   output logic       SSPOE_B,
   output logic       SSPTXINTR,
   output logic       SSPRXINTR,
   output logic       SSPRXOVR
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_DATA} tx_state_t;

   logic [DW-1:0]     div_q;
   logic              sclk_q, rise_tick, fall_div;
   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [AW-1:0]     tx_wr_q, tx_rd_q;
   logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
   logic              tx_push, tx_pop, tx_empty, txintr_q;
   tx_state_t         tx_state_q, tx_state_d;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d, tx_shifted;
   logic [BW-1:0]     tx_bit_q, tx_bit_d;
   logic              tx_pend_q, tx_pend_d, tx_first;
   logic              fss_q, fss_d, txd_q, txd_d, oe_b_q, oe_b_d;
   logic [2:0]        rx_src, s1_q, s2_q;
   logic              clk3_q, fall_tick;
   logic              rx_armed_q, rx_wr_q;
   logic [BW-1:0]     rx_bit_q;
   logic [DATA_W-1:0] rx_sh_q, rx_shifted;
   logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0]     rx_wr_ptr_q, rx_rd_ptr_q;
   logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
   logic              rx_push, rx_pop, ovr_set, rxintr_q, ovr_q;
   logic [DATA_W-1:0] prdata_q;

   assign rise_tick = (div_q == DW'(CLK_DIV / 2 - 1));
   assign fall_div  = (div_q == DW'(CLK_DIV - 1));

   always_ff @(posedge PCLK) begin
      if (CLEAR) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         div_q <= fall_div ? '0 : div_q + DW'(1);
         if (rise_tick)     sclk_q <= 1'b1;
         else if (fall_div) sclk_q <= 1'b0;
      end
   end

   generate
      if (LSB_FIRST != 0) begin : g_lsb
         assign tx_first   = tx_sh_q[0];
         assign tx_shifted = {1'b0, tx_sh_q[DATA_W-1:1]};
         assign rx_shifted = {s2_q[0], rx_sh_q[DATA_W-1:1]};
      end else begin : g_msb
         assign tx_first   = tx_sh_q[DATA_W-1];
         assign tx_shifted = {tx_sh_q[DATA_W-2:0], 1'b0};
         assign rx_shifted = {rx_sh_q[DATA_W-2:0], s2_q[0]};
      end
   endgenerate

   assign tx_empty = (tx_cnt_q == '0);
   assign tx_push  = bus.PSEL & bus.PWRITE & (tx_cnt_q != FULL);
   assign tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);

   always_ff @(posedge PCLK) begin
      if (tx_push) tx_mem[tx_wr_q] <= bus.PWDATA;
   end

   always_ff @(posedge PCLK) begin
      if (CLEAR) begin
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         tx_cnt_q <= '0;
         txintr_q <= 1'b0;
      end else begin
         if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
         if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
         tx_cnt_q <= tx_cnt_d;
         txintr_q <= (tx_cnt_d == FULL);
      end
   end

   // A pending word (popped alongside the previous LSB) makes the cnt=0 tick act as SYNC.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_sh_d    = tx_sh_q;
      tx_bit_d   = tx_bit_q;
      tx_pend_d  = tx_pend_q;
      fss_d      = fss_q;
      txd_d      = txd_q;
      oe_b_d     = oe_b_q;
      tx_pop     = 1'b0;
      if (rise_tick) begin
         if (tx_state_q == TX_SYNC ||
             (tx_state_q == TX_DATA && tx_bit_q == '0 && tx_pend_q)) begin
            fss_d      = 1'b0;
            oe_b_d     = 1'b0;
            txd_d      = tx_first;
            tx_sh_d    = tx_shifted;
            tx_bit_d   = BW'(DATA_W - 1);
            tx_pend_d  = 1'b0;
            tx_state_d = TX_DATA;
         end else if (tx_state_q == TX_DATA && tx_bit_q != '0) begin
            txd_d    = tx_first;
            tx_sh_d  = tx_shifted;
            tx_bit_d = tx_bit_q - BW'(1);
            if (tx_bit_q == BW'(1) && !tx_empty) begin
               tx_pop    = 1'b1;
               tx_sh_d   = tx_mem[tx_rd_q];
               fss_d     = 1'b1;
               tx_pend_d = 1'b1;
            end
         end else begin
            oe_b_d = 1'b1;
            txd_d  = 1'b0;
            fss_d  = !tx_empty;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_sh_d    = tx_mem[tx_rd_q];
               tx_state_d = TX_SYNC;
            end else begin
               tx_state_d = TX_IDLE;
            end
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (CLEAR) begin
         tx_state_q <= TX_IDLE;
         tx_sh_q    <= '0;
         tx_bit_q   <= '0;
         tx_pend_q  <= 1'b0;
         fss_q      <= 1'b0;
         txd_q      <= 1'b0;
         oe_b_q     <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_sh_q    <= tx_sh_d;
         tx_bit_q   <= tx_bit_d;
         tx_pend_q  <= tx_pend_d;
         fss_q      <= fss_d;
         txd_q      <= txd_d;
         oe_b_q     <= oe_b_d;
      end
   end

   // Clock, frame sync and data share one synchroniser so they stay cycle-aligned.
   assign rx_src    = LOOPBACK ? {sclk_q, fss_q, txd_q} : {SSPCLKIN, SSPFSSIN, SSPRXD};
   assign fall_tick = clk3_q & ~s2_q[2];

   always_ff @(posedge PCLK) begin
      if (CLEAR) begin
         s1_q       <= '0;
         s2_q       <= '0;
         clk3_q     <= 1'b0;
         rx_armed_q <= 1'b0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_wr_q    <= 1'b0;
      end else begin
         s1_q    <= rx_src;
         s2_q    <= s1_q;
         clk3_q  <= s2_q[2];
         rx_wr_q <= 1'b0;
         if (fall_tick) begin
            if (s2_q[1]) begin
               // Back-to-back frames raise FSS during the last bit: finish that word first.
               if (rx_armed_q && rx_bit_q == BW'(1)) begin
                  rx_sh_q <= rx_shifted;
                  rx_wr_q <= 1'b1;
               end
               rx_armed_q <= 1'b1;
               rx_bit_q   <= BW'(DATA_W);
            end else if (rx_armed_q) begin
               rx_sh_q  <= rx_shifted;
               rx_bit_q <= rx_bit_q - BW'(1);
               if (rx_bit_q == BW'(1)) begin
                  rx_armed_q <= 1'b0;
                  rx_wr_q    <= 1'b1;
               end
            end
         end
      end
   end

   assign rx_push  = rx_wr_q & (rx_cnt_q != FULL);
   assign ovr_set  = rx_wr_q & (rx_cnt_q == FULL);
   assign rx_pop   = bus.PSEL & ~bus.PWRITE & (rx_cnt_q != '0);
   assign rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

   always_ff @(posedge PCLK) begin
      if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_sh_q;
   end

   always_ff @(posedge PCLK) begin
      if (CLEAR) begin
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
         rx_cnt_q    <= '0;
         rxintr_q    <= 1'b0;
         ovr_q       <= 1'b0;
         prdata_q    <= '0;
      end else begin
         if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + AW'(1);
         if (rx_pop) begin
            rx_rd_ptr_q <= rx_rd_ptr_q + AW'(1);
            prdata_q    <= rx_mem[rx_rd_ptr_q];
         end
         rx_cnt_q <= rx_cnt_d;
         rxintr_q <= (rx_cnt_d == FULL);
         if (ovr_set)     ovr_q <= 1'b1;
         else if (rx_pop) ovr_q <= 1'b0;
      end
   end

   assign bus.PRDATA = prdata_q;
   assign SSPCLKOUT  = sclk_q;
   assign SSPFSSOUT  = fss_q;
   assign SSPTXD     = txd_q;
   assign SSPOE_B    = oe_b_q;
   assign SSPTXINTR  = txintr_q;
   assign SSPRXINTR  = rxintr_q;
   assign SSPRXOVR   = ovr_q;
endmodule

// File: tb/tb_ssp_param.sv
// Directed bench for ssp_param: an MSB-first instance for transmit checks and an
// LSB-first loopback instance for receive, FIFO-full and overrun checks.
module tb_ssp_param;
   localparam int W   = 8;
   localparam int D   = 4;
   localparam int DIV = 8;

   logic PCLK = 1'b0;
   logic CLEAR = 1'b1;
   always #5 PCLK = ~PCLK;

   ssp_param_if #(.DATA_W(W)) b1 ();
   ssp_param_if #(.DATA_W(W)) b2 ();

   logic clk1, fss1, txd1, oeb1, txi1, rxi1, ovr1;
   logic clk2, fss2, txd2, oeb2, txi2, rxi2, ovr2;

   ssp_param #(.DATA_W(W), .FIFO_DEPTH(D), .CLK_DIV(DIV), .LSB_FIRST(0)) u_msb (
      .PCLK(PCLK), .CLEAR(CLEAR), .bus(b1), .LOOPBACK(1'b0),
      .SSPCLKIN(1'b0), .SSPFSSIN(1'b0), .SSPRXD(1'b0),
      .SSPCLKOUT(clk1), .SSPFSSOUT(fss1), .SSPTXD(txd1), .SSPOE_B(oeb1),
      .SSPTXINTR(txi1), .SSPRXINTR(rxi1), .SSPRXOVR(ovr1));

   ssp_param #(.DATA_W(W), .FIFO_DEPTH(D), .CLK_DIV(DIV), .LSB_FIRST(1)) u_lsb (
      .PCLK(PCLK), .CLEAR(CLEAR), .bus(b2), .LOOPBACK(1'b1),
      .SSPCLKIN(1'b0), .SSPFSSIN(1'b0), .SSPRXD(1'b0),
      .SSPCLKOUT(clk2), .SSPFSSOUT(fss2), .SSPTXD(txd2), .SSPOE_B(oeb2),
      .SSPTXINTR(txi2), .SSPRXINTR(rxi2), .SSPRXOVR(ovr2));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int which, input logic [7:0] d);
      if (which == 1) begin b1.PSEL = 1'b1; b1.PWRITE = 1'b1; b1.PWDATA = d; end
      else            begin b2.PSEL = 1'b1; b2.PWRITE = 1'b1; b2.PWDATA = d; end
      @(negedge PCLK);
      b1.PSEL = 1'b0;
      b2.PSEL = 1'b0;
      $display("[%0t] dut%0d write 0x%02h", $time, which, d);
   endtask

   task automatic rd(input int which, output logic [7:0] d);
      if (which == 1) begin b1.PSEL = 1'b1; b1.PWRITE = 1'b0; end
      else            begin b2.PSEL = 1'b1; b2.PWRITE = 1'b0; end
      @(negedge PCLK);
      b1.PSEL = 1'b0;
      b2.PSEL = 1'b0;
      d = (which == 1) ? b1.PRDATA : b2.PRDATA;
      $display("[%0t] dut%0d read 0x%02h", $time, which, d);
   endtask

   // Advance to the negedge just after SSPCLKOUT rises (the outputs of that period).
   task automatic next_rise();
      logic last;
      bit   seen;
      last = clk1;
      seen = 1'b0;
      for (int i = 0; i < 2 * DIV && !seen; i++) begin
         @(negedge PCLK);
         if (clk1 && !last) seen = 1'b1;
         last = clk1;
      end
      if (!seen) chk("rise_timeout", {15'd0, seen}, 16'd1);
   endtask

   task automatic wait_fss(input string tag);
      for (int i = 0; i < 3 && !fss1; i++) next_rise();
      chk({tag, "_fss_start"}, fss1, 1'b1);
   endtask

   // Checks the eight data periods of a word; fss_last is FSS expected during the LSB period.
   task automatic tx_word(input logic [7:0] w, input bit fss_last, input string tag);
      for (int i = 7; i >= 0; i--) begin
         next_rise();
         chk($sformatf("%s_txd%0d", tag, i), txd1, w[i]);
         chk($sformatf("%s_oeb%0d", tag, i), oeb1, 1'b0);
         chk($sformatf("%s_fss%0d", tag, i), fss1, (i == 0) ? fss_last : 1'b0);
      end
      $display("[%0t] dut1 frame 0x%02h checked", $time, w);
   endtask

   task automatic idle_after(input string tag);
      next_rise();
      chk({tag, "_oeb_end"}, oeb1, 1'b1);
      chk({tag, "_txd_end"}, txd1, 1'b0);
      chk({tag, "_fss_end"}, fss1, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      b1.PSEL = 1'b0; b1.PWRITE = 1'b0; b1.PWDATA = '0;
      b2.PSEL = 1'b0; b2.PWRITE = 1'b0; b2.PWDATA = '0;
      CLEAR = 1'b1;
      repeat (3) @(negedge PCLK);
      CLEAR = 1'b0;

      // Start a frame, then reset in the middle of it.
      wr(1, 8'hFF);
      wait_fss("pre");
      next_rise();
      chk("mid_frame_oeb", oeb1, 1'b0);
      CLEAR = 1'b1;
      @(negedge PCLK);
      chk("rst_clkout", clk1, 1'b0);
      chk("rst_fss", fss1, 1'b0);
      chk("rst_txd", txd1, 1'b0);
      chk("rst_oeb", oeb1, 1'b1);
      chk("rst_prdata", b1.PRDATA, 8'h00);
      chk("rst_txintr", txi1, 1'b0);
      chk("rst_rxintr", rxi1, 1'b0);
      chk("rst_ovr", ovr1, 1'b0);
      CLEAR = 1'b0;
      repeat (DIV / 2 - 1) @(negedge PCLK);
      chk("first_rise_early", clk1, 1'b0);
      @(negedge PCLK);
      chk("first_rise", clk1, 1'b1);
      next_rise();
      chk("abort_no_frame_oeb", oeb1, 1'b1);
      chk("abort_no_frame_fss", fss1, 1'b0);

      // Single isolated frame.
      wr(1, 8'hA5);
      wait_fss("single");
      tx_word(8'hA5, 1'b0, "single");
      idle_after("single");

      // Back-to-back frames: sync overlaps the previous LSB.
      wr(1, 8'h3C);
      wr(1, 8'hC3);
      wait_fss("b2b");
      tx_word(8'h3C, 1'b1, "b2b0");
      tx_word(8'hC3, 1'b0, "b2b1");
      idle_after("b2b");

      // TX FIFO full: five writes between two ticks, fifth dropped.
      next_rise();
      wr(1, 8'h11);
      wr(1, 8'h22);
      wr(1, 8'h33);
      chk("txintr_3", txi1, 1'b0);
      wr(1, 8'h44);
      chk("txintr_4", txi1, 1'b1);
      wr(1, 8'h55);
      chk("txintr_5", txi1, 1'b1);
      wait_fss("full");
      chk("txintr_after_pop", txi1, 1'b0);
      tx_word(8'h11, 1'b1, "full0");
      tx_word(8'h22, 1'b1, "full1");
      tx_word(8'h33, 1'b1, "full2");
      tx_word(8'h44, 1'b0, "full3");
      idle_after("full");

      // Loopback, LSB first.
      wr(2, 8'h5A);
      wr(2, 8'h81);
      repeat (200) @(negedge PCLK);
      chk("lb_rxintr", rxi2, 1'b0);
      chk("lb_ovr", ovr2, 1'b0);
      rd(2, d);
      chk("lb_rd0", d, 8'h5A);
      rd(2, d);
      chk("lb_rd1", d, 8'h81);
      rd(2, d);
      chk("lb_rd_empty_hold", d, 8'h81);

      // Overrun: five isolated loopback frames, no reads.
      for (int k = 1; k <= 5; k++) begin
         wr(2, 8'(k));
         repeat (120) @(negedge PCLK);
         chk($sformatf("ovr_rxintr_%0d", k), rxi2, (k >= 4) ? 1'b1 : 1'b0);
         chk($sformatf("ovr_flag_%0d", k), ovr2, (k == 5) ? 1'b1 : 1'b0);
      end
      rd(2, d);
      chk("ovr_rd1", d, 8'h01);
      chk("ovr_cleared", ovr2, 1'b0);
      chk("ovr_rxintr_after_rd", rxi2, 1'b0);
      rd(2, d);
      chk("ovr_rd2", d, 8'h02);
      rd(2, d);
      chk("ovr_rd3", d, 8'h03);
      rd(2, d);
      chk("ovr_rd4", d, 8'h04);
      rd(2, d);
      chk("ovr_rd_empty_hold", d, 8'h04);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
